// File: rtl/focus_peak_track_if.sv
// rtl/focus_peak_track_if.sv - sweeper-side bus of the autofocus peak tracker
interface focus_peak_track_if #(
  parameter int FV_W = 24
);
  logic            start;
  logic [10:0]     step;
  logic            v_c;
  logic            vcm_end;
  logic [FV_W-1:0] fv;
  logic            fv_valid;
  logic [9:0]      step_up;
  logic [FV_W-1:0] peak_fv;
  logic [10:0]     final_step;
  logic            busy;
  logic            af_done;

  modport master (
    output start, step, v_c, vcm_end, fv, fv_valid,
    input  step_up, peak_fv, final_step, busy, af_done
  );

  modport slave (
    input  start, step, v_c, vcm_end, fv, fv_valid,
    output step_up, peak_fv, final_step, busy, af_done
  );
endinterface

// File: rtl/focus_peak_track.sv
// rtl/focus_peak_track.sv - autofocus peak tracker: coarse peak -> STEP_UP, fine peak -> FINAL_STEP
module focus_peak_track #(
  parameter int        FV_W     = 24,
  parameter int        SKIP_N   = 2,
  parameter logic [9:0] MIN_STEP = 10'd5,
  parameter logic [9:0] MAX_STEP = 10'h3FF
) (
  input  logic clk,
  input  logic rst,
  focus_peak_track_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COARSE, FINE, DONE} state_t;

  localparam logic [7:0] SKIP_INIT = 8'(SKIP_N);

  state_t          state;
  logic            vc_q;
  logic            end_q;
  logic [7:0]      skip_cnt;
  logic [10:0]     best_step;
  logic [FV_W-1:0] peak_fv;
  logic [9:0]      step_up;
  logic [10:0]     final_step;
  logic            busy;
  logic            af_done;

  logic            vc_rise;
  logic            end_rise;
  logic            in_sweep;
  logic            take;
  logic [FV_W-1:0] peak_nxt;
  logic [10:0]     best_nxt;
  logic [7:0]      skip_nxt;
  logic [9:0]      clamped;

  // 11-bit compare so a set bit 10 falls into the upper clamp
  function automatic logic [9:0] clamp_step(input logic [10:0] s);
    if (s > {1'b0, MAX_STEP})
      return MAX_STEP;
    else if (s < {1'b0, MIN_STEP})
      return MIN_STEP;
    else
      return s[9:0];
  endfunction

  always_comb begin
    vc_rise  = bus.v_c & ~vc_q;
    end_rise = bus.vcm_end & ~end_q;
    in_sweep = (state == COARSE) || (state == FINE);
    take     = in_sweep && bus.fv_valid && (skip_cnt == 8'd0) && (bus.fv > peak_fv);
    peak_nxt = take ? bus.fv : peak_fv;
    best_nxt = take ? bus.step : best_step;
    skip_nxt = (in_sweep && bus.fv_valid && (skip_cnt != 8'd0)) ? skip_cnt - 8'd1 : skip_cnt;
    clamped  = clamp_step(best_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vc_q       <= 1'b0;
      end_q      <= 1'b0;
      skip_cnt   <= 8'd0;
      best_step  <= 11'd0;
      peak_fv    <= '0;
      step_up    <= MIN_STEP;
      final_step <= 11'd0;
      busy       <= 1'b0;
      af_done    <= 1'b0;
    end else begin
      vc_q  <= bus.v_c;
      end_q <= bus.vcm_end;
      if (bus.start) begin
        state      <= COARSE;
        skip_cnt   <= SKIP_INIT;
        best_step  <= 11'd0;
        peak_fv    <= '0;
        step_up    <= MIN_STEP;
        final_step <= 11'd0;
        busy       <= 1'b1;
        af_done    <= 1'b0;
      end else begin
        case (state)
          COARSE: begin
            if (vc_rise) begin
              // same-cycle sample is already folded into clamped
              step_up   <= clamped;
              best_step <= {1'b0, clamped};
              peak_fv   <= '0;
              skip_cnt  <= SKIP_INIT;
              state     <= FINE;
            end else begin
              peak_fv   <= peak_nxt;
              best_step <= best_nxt;
              skip_cnt  <= skip_nxt;
            end
          end
          FINE: begin
            peak_fv   <= peak_nxt;
            best_step <= best_nxt;
            skip_cnt  <= skip_nxt;
            if (end_rise) begin
              final_step <= best_nxt;
              af_done    <= 1'b1;
              busy       <= 1'b0;
              state      <= DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.step_up    = step_up;
  assign bus.peak_fv    = peak_fv;
  assign bus.final_step = final_step;
  assign bus.busy       = busy;
  assign bus.af_done    = af_done;
endmodule

// File: tb/tb_focus_peak_track.sv
// tb/tb_focus_peak_track.sv - scoreboard bench: SKIP_N=0 (a) and SKIP_N=2 (b) instances on shared stimulus
module tb_focus_peak_track;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [10:0] step = 11'd0;
  logic        v_c = 1'b0;
  logic        vcm_end = 1'b0;
  logic [23:0] fv = 24'd0;
  logic        fv_valid = 1'b0;

  focus_peak_track_if #(.FV_W(24)) a ();
  focus_peak_track_if #(.FV_W(24)) b ();

  assign a.start = start;  assign b.start = start;
  assign a.step = step;    assign b.step = step;
  assign a.v_c = v_c;      assign b.v_c = v_c;
  assign a.vcm_end = vcm_end; assign b.vcm_end = vcm_end;
  assign a.fv = fv;        assign b.fv = fv;
  assign a.fv_valid = fv_valid; assign b.fv_valid = fv_valid;

  focus_peak_track #(.FV_W(24), .SKIP_N(0), .MIN_STEP(10'd5), .MAX_STEP(10'h3FF))
    dut_a (.clk(clk), .rst(rst), .bus(a));
  focus_peak_track #(.FV_W(24), .SKIP_N(2), .MIN_STEP(10'd5), .MAX_STEP(10'h3FF))
    dut_b (.clk(clk), .rst(rst), .bus(b));

  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] sb[$];
  logic [31:0] e;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic sample(input logic [23:0] f, input logic [10:0] s);
    fv = f; step = s; fv_valid = 1'b1;
    tick();
    fv_valid = 1'b0;
  endtask

  task automatic idle_lines();
    v_c = 1'b0; vcm_end = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    sb.push_back(32'd5); sb.push_back(32'd0); sb.push_back(32'd0); sb.push_back(32'd0); sb.push_back(32'd0);
    rst = 1'b1;
    tick(); tick();
    e = sb.pop_front(); n_tests++;
    if ({22'd0, a.step_up} !== e) begin n_fail++; $display("FAIL reset_step_up got %0d want %0d", a.step_up, e); end
    e = sb.pop_front(); n_tests++;
    if ({8'd0, a.peak_fv} !== e) begin n_fail++; $display("FAIL reset_peak_fv got %0d want %0d", a.peak_fv, e); end
    e = sb.pop_front(); n_tests++;
    if ({21'd0, a.final_step} !== e) begin n_fail++; $display("FAIL reset_final_step got %0d want %0d", a.final_step, e); end
    e = sb.pop_front(); n_tests++;
    if ({31'd0, a.busy} !== e) begin n_fail++; $display("FAIL reset_busy got %0d want %0d", a.busy, e); end
    e = sb.pop_front(); n_tests++;
    if ({31'd0, a.af_done} !== e) begin n_fail++; $display("FAIL reset_af_done got %0d want %0d", a.af_done, e); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_coarse_fine();
    pulse_start();
    sb.push_back(32'd1);
    e = sb.pop_front(); n_tests++;
    if ({31'd0, a.busy} !== e) begin n_fail++; $display("FAIL start_busy got %0d want %0d", a.busy, e); end
    sample(24'd100, 11'd0); sample(24'd500, 11'd20); sample(24'd300, 11'd30);
    sb.push_back(32'd500);
    e = sb.pop_front(); n_tests++;
    if ({8'd0, a.peak_fv} !== e) begin n_fail++; $display("FAIL coarse_peak_fv got %0d want %0d", a.peak_fv, e); end
    v_c = 1'b1;
    sb.push_back(32'd20); sb.push_back(32'd0);
    tick();
    e = sb.pop_front(); n_tests++;
    if ({22'd0, a.step_up} !== e) begin n_fail++; $display("FAIL coarse_step_up got %0d want %0d", a.step_up, e); end
    e = sb.pop_front(); n_tests++;
    if ({8'd0, a.peak_fv} !== e) begin n_fail++; $display("FAIL fine_entry_peak got %0d want %0d", a.peak_fv, e); end
    sample(24'd200, 11'd18); sample(24'd450, 11'd21); sample(24'd450, 11'd22);
    vcm_end = 1'b1;
    sb.push_back(32'd21); sb.push_back(32'd1); sb.push_back(32'd0); sb.push_back(32'd20);
    tick();
    e = sb.pop_front(); n_tests++;
    if ({21'd0, a.final_step} !== e) begin n_fail++; $display("FAIL fine_final_step got %0d want %0d", a.final_step, e); end
    e = sb.pop_front(); n_tests++;
    if ({31'd0, a.af_done} !== e) begin n_fail++; $display("FAIL fine_af_done got %0d want %0d", a.af_done, e); end
    e = sb.pop_front(); n_tests++;
    if ({31'd0, a.busy} !== e) begin n_fail++; $display("FAIL fine_busy got %0d want %0d", a.busy, e); end
    e = sb.pop_front(); n_tests++;
    if ({22'd0, a.step_up} !== e) begin n_fail++; $display("FAIL done_step_up_hold got %0d want %0d", a.step_up, e); end
    idle_lines();
  endtask

  task automatic test_skip_and_min_clamp();
    pulse_start();
    sample(24'd900, 11'd0); sample(24'd800, 11'd10); sample(24'd50, 11'd20); sample(24'd60, 11'd30);
    v_c = 1'b1;
    sb.push_back(32'd30); sb.push_back(32'd5);
    tick();
    e = sb.pop_front(); n_tests++;
    if ({22'd0, b.step_up} !== e) begin n_fail++; $display("FAIL skip_step_up got %0d want %0d", b.step_up, e); end
    e = sb.pop_front(); n_tests++;
    if ({22'd0, a.step_up} !== e) begin n_fail++; $display("FAIL min_clamp_step_up got %0d want %0d", a.step_up, e); end
    idle_lines();
  endtask

  task automatic test_max_clamp();
    pulse_start();
    sample(24'd700, 11'h40A);
    v_c = 1'b1;
    sb.push_back(32'h3FF); sb.push_back(32'd5);
    tick();
    e = sb.pop_front(); n_tests++;
    if ({22'd0, a.step_up} !== e) begin n_fail++; $display("FAIL max_clamp_step_up got %0d want %0d", a.step_up, e); end
    e = sb.pop_front(); n_tests++;
    if ({22'd0, b.step_up} !== e) begin n_fail++; $display("FAIL no_sample_step_up got %0d want %0d", b.step_up, e); end
    idle_lines();
  endtask

  task automatic test_same_cycle();
    pulse_start();
    sample(24'd500, 11'd20);
    fv = 24'd999; step = 11'd40; fv_valid = 1'b1; v_c = 1'b1;
    sb.push_back(32'd40); sb.push_back(32'd5);
    tick();
    fv_valid = 1'b0;
    e = sb.pop_front(); n_tests++;
    if ({22'd0, a.step_up} !== e) begin n_fail++; $display("FAIL same_cycle_step_up got %0d want %0d", a.step_up, e); end
    e = sb.pop_front(); n_tests++;
    if ({22'd0, b.step_up} !== e) begin n_fail++; $display("FAIL same_cycle_skip_step_up got %0d want %0d", b.step_up, e); end
    idle_lines();
  endtask

  task automatic test_reset_mid_search();
    pulse_start();
    sample(24'd800, 11'd60);
    v_c = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    sb.push_back(32'd5); sb.push_back(32'd0);
    e = sb.pop_front(); n_tests++;
    if ({22'd0, a.step_up} !== e) begin n_fail++; $display("FAIL midreset_step_up got %0d want %0d", a.step_up, e); end
    e = sb.pop_front(); n_tests++;
    if ({31'd0, a.busy} !== e) begin n_fail++; $display("FAIL midreset_busy got %0d want %0d", a.busy, e); end
    tick();
    rst = 1'b0;
    v_c = 1'b1;
    tick();
    pulse_start();
    vcm_end = 1'b1;
    sb.push_back(32'd0);
    tick();
    e = sb.pop_front(); n_tests++;
    if ({31'd0, a.af_done} !== e) begin n_fail++; $display("FAIL stale_vc_af_done got %0d want %0d", a.af_done, e); end
    vcm_end = 1'b0; v_c = 1'b0;
    tick();
    v_c = 1'b1;
    tick();
    vcm_end = 1'b1;
    sb.push_back(32'd5); sb.push_back(32'd5); sb.push_back(32'd1);
    tick();
    e = sb.pop_front(); n_tests++;
    if ({22'd0, a.step_up} !== e) begin n_fail++; $display("FAIL empty_step_up got %0d want %0d", a.step_up, e); end
    e = sb.pop_front(); n_tests++;
    if ({21'd0, a.final_step} !== e) begin n_fail++; $display("FAIL empty_final_step got %0d want %0d", a.final_step, e); end
    e = sb.pop_front(); n_tests++;
    if ({31'd0, a.af_done} !== e) begin n_fail++; $display("FAIL empty_af_done got %0d want %0d", a.af_done, e); end
    sample(24'd5000, 11'd99);
    sb.push_back(32'd0);
    e = sb.pop_front(); n_tests++;
    if ({8'd0, a.peak_fv} !== e) begin n_fail++; $display("FAIL done_peak_hold got %0d want %0d", a.peak_fv, e); end
    idle_lines();
  endtask

  initial begin
    test_reset();
    test_coarse_fine();
    test_skip_and_min_clamp();
    test_max_clamp();
    test_same_cycle();
    test_reset_mid_search();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
